wait_state_ram: RTL and testbench

WAIT_STATE_RAM -- requirements
Module: wait_state_ram

---
 rtl/wait_state_ram_if.sv | 21 ++
 rtl/wait_state_ram.sv | 105 ++++++++++
 tb/tb_wait_state_ram.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wait_state_ram_if.sv
// Host/agent bus bundle for wait_state_ram: 32-bit word bus with byte
// enables and an agent-driven waitrequest stall.
interface wait_state_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/wait_state_ram.sv
// Single-port word RAM with a fixed number of wait states per access.
// Define WAIT_STATE_RAM_TRACE_EN to print one line per completed access.
module wait_state_ram #(
  parameter int          WORDS       = 1024,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] FILL        = 32'hDEAD_BEEF
) (
  input logic             clk,
  input logic             rst,
  wait_state_ram_if.slave bus
);

  localparam int         AW       = $clog2(WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        waitreq;
  logic        load;

  logic [31:0] mem [WORDS];

  logic          req;
  logic          in_range;
  logic [AW-1:0] idx;

  assign req      = bus.read | bus.write;
  assign in_range = {2'b00, bus.address[31:2]} < 32'(WORDS);
  assign idx      = bus.address[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;
    waitreq    = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        waitreq = req;
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ACK;
            load    = 1'b1;
          end
        end
      end
      WAIT: begin
        waitreq = 1'b1;
        // Host withdrew the request: abandon quietly.
        if (!req)
          state_d = IDLE;
        else if (cnt_q == 4'd0) begin
          state_d = ACK;
          load    = 1'b1;
        end else
          cnt_d = cnt_q - 4'd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A combined read+write is a write, so readdata is left alone.
    if (load && !bus.write)
      readdata_d = in_range ? mem[idx] : FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  // Writes commit on the edge that closes ACK; memory is never reset.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ACK && bus.write && in_range) begin
      for (int i = 0; i < 4; i++)
        if (bus.byteenable[i])
          mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.waitrequest = waitreq;

`ifdef WAIT_STATE_RAM_TRACE_EN
  always @(posedge clk) begin
    if (!rst && state_q == ACK)
      $display("wait_state_ram: %s addr=%h data=%h be=%b",
               bus.write ? "W" : "R", bus.address,
               bus.write ? bus.writedata : readdata_q, bus.byteenable);
  end
`endif

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench for wait_state_ram: vector table on a 2-wait-state
// instance plus hand sequences for abort, reset and zero-wait back-to-back.
module tb_wait_state_ram;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wait_state_ram_if bus0();
  wait_state_ram_if bus1();

  wait_state_ram #(.WORDS(1024), .WAIT_STATES(2), .FILL(32'hDEAD_BEEF)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  wait_state_ram #(.WORDS(1024), .WAIT_STATES(0), .FILL(32'hDEAD_BEEF)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 = read, 1 = write, 2 = read+write
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  // Full access on dut0, started just after a rising edge; returns the
  // readdata seen in ACK and the number of stalled cycles before it.
  task automatic access0(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rd, output int hi);
    bit done = 0;
    bus0.address    = addr;
    bus0.read       = (kind != 1);
    bus0.write      = (kind != 0);
    bus0.writedata  = wdata;
    bus0.byteenable = be;
    hi = 0;
    rd = 'x;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!bus0.waitrequest) begin
        rd   = bus0.readdata;
        done = 1;
      end else
        hi++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: got no ack expected ack within 40 cycles");
    end
    @(posedge clk);
    #1;
    bus0.read  = 1'b0;
    bus0.write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          hi;

    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          hi;

    vecs[0]  = '{1, 32'h100,  32'h1122_3344, 4'hF,    32'h0};
    vecs[1]  = '{0, 32'h100,  32'h0,         4'h0,    32'h1122_3344};
    vecs[2]  = '{1, 32'h100,  32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[3]  = '{0, 32'h100,  32'h0,         4'h0,    32'h11BB_33DD};
    vecs[4]  = '{0, 32'h103,  32'h0,         4'h0,    32'h11BB_33DD};
    vecs[5]  = '{0, 32'h1000, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[6]  = '{1, 32'h0,    32'h0A0B_0C0D, 4'hF,    32'h0};
    vecs[7]  = '{1, 32'h1000, 32'hFFFF_FFFF, 4'hF,    32'h0};
    vecs[8]  = '{0, 32'h0,    32'h0,         4'h0,    32'h0A0B_0C0D};
    vecs[9]  = '{1, 32'hFFC,  32'hCAFE_F00D, 4'hF,    32'h0};
    vecs[10] = '{0, 32'hFFC,  32'h0,         4'h0,    32'hCAFE_F00D};
    vecs[11] = '{2, 32'h200,  32'h5566_7788, 4'hF,    32'hCAFE_F00D};
    vecs[12] = '{0, 32'h200,  32'h0,         4'h0,    32'h5566_7788};
    vecs[13] = '{1, 32'h200,  32'h0000_0000, 4'b1000, 32'h0};
    vecs[14] = '{0, 32'h200,  32'h0,         4'h0,    32'h0066_7788};

    rst = 1'b1;
    bus0.address = '0; bus0.read = 0; bus0.write = 0; bus0.writedata = '0; bus0.byteenable = '0;
    bus1.address = '0; bus1.read = 0; bus1.write = 0; bus1.writedata = '0; bus1.byteenable = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readdata0", bus0.readdata, 32'h0);
    check("rst_waitreq0_idle", {31'd0, bus0.waitrequest}, 32'd0);
    check("rst_readdata1", bus1.readdata, 32'h0);
    bus0.read = 1'b1;
    #1;
    check("rst_waitreq0_follows_read", {31'd0, bus0.waitrequest}, 32'd1);
    bus0.read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      access0(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, hi);
      check($sformatf("vec%0d_stall", i), 32'(hi), 32'd3);
      if (vecs[i].kind != 1)
        check($sformatf("vec%0d_readdata", i), rd, vecs[i].exp_rd);
    end

    // Request withdrawn during WAIT: no write, readdata untouched.
    access0(1, 32'h300, 32'h0101_0101, 4'hF, rd, hi);
    access0(0, 32'h100, 32'h0, 4'h0, rd, hi);
    check("pre_drop_read", rd, 32'h11BB_33DD);
    bus0.address = 32'h300; bus0.writedata = 32'hFFFF_FFFF; bus0.byteenable = 4'hF;
    bus0.write = 1'b1;
    @(posedge clk);
    #1;
    bus0.write = 1'b0;
    @(negedge clk);
    check("drop_wait_stall", {31'd0, bus0.waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drop_back_idle", {31'd0, bus0.waitrequest}, 32'd0);
    check("drop_readdata_kept", bus0.readdata, 32'h11BB_33DD);
    @(posedge clk);
    #1;
    access0(0, 32'h300, 32'h0, 4'h0, rd, hi);
    check("drop_old_value", rd, 32'h0101_0101);

    // Reset during WAIT of a write: access aborted, memory intact.
    access0(1, 32'h8, 32'h0, 4'hF, rd, hi);
    bus0.address = 32'h8; bus0.writedata = 32'h1234_5678; bus0.byteenable = 4'hF;
    bus0.write = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_wait_stall", {31'd0, bus0.waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus0.write = 1'b0;
    @(negedge clk);
    check("rst_abort_readdata", bus0.readdata, 32'h0);
    check("rst_abort_idle", {31'd0, bus0.waitrequest}, 32'd0);
    @(posedge clk);
    #1;
    access0(0, 32'h8, 32'h0, 4'h0, rd, hi);
    check("rst_abort_stall", 32'(hi), 32'd3);
    check("rst_abort_mem", rd, 32'h0);
    access0(0, 32'h0, 32'h0, 4'h0, rd, hi);
    check("mem_survives_rst", rd, 32'h0A0B_0C0D);

    // Zero wait states: write then two back-to-back reads, 1,0 each.
    bus1.address = 32'h10; bus1.writedata = 32'h600D_CAFE; bus1.byteenable = 4'hF;
    bus1.write = 1'b1;
    @(negedge clk);
    check("ws0_wr_req", {31'd0, bus1.waitrequest}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("ws0_wr_ack", {31'd0, bus1.waitrequest}, 32'd0);
    @(posedge clk);
    #1;
    bus1.write = 1'b0;
    bus1.read  = 1'b1;
    @(negedge clk);
    check("ws0_rd1_req", {31'd0, bus1.waitrequest}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("ws0_rd1_ack", {31'd0, bus1.waitrequest}, 32'd0);
    check("ws0_rd1_data", bus1.readdata, 32'h600D_CAFE);
    @(posedge clk);
    #1;
    bus1.address = 32'h1000;
    @(negedge clk);
    check("ws0_rd2_req", {31'd0, bus1.waitrequest}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("ws0_rd2_ack", {31'd0, bus1.waitrequest}, 32'd0);
    check("ws0_rd2_data", bus1.readdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus1.read = 1'b0;
    @(negedge clk);
    check("ws0_idle", {31'd0, bus1.waitrequest}, 32'd0);
    check("ws0_hold", bus1.readdata, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
